// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle WIDTH-bit adder built around one 4-bit slice.
// It handles one nibble per clock and registers the carry between nibbles.
// Operands come in and results go out through valid/ready handshakes.
// Optional feature: define NIBBLE_SERIAL_ADDER_OVERFLOW_EN to add the registered
// signed-overflow output ovf.

module Adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);

    // Plain 4-bit ripple add; the 5-bit result splits into carry and sum
    always_comb begin
        {c_out, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
    end

endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    // WIDTH must be a multiple of 4 and at least 8, so NIB is always >= 2
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [3:0]       nib_sum;
    logic             nib_cout;

    Adder_4bit u_slice (
        .a     (a_sh[3:0]),
        .b     (b_sh[3:0]),
        .c_in  (carry),
        .sum   (nib_sum),
        .c_out (nib_cout)
    );

    assign sum   = res;
    assign c_out = carry;

    // Control FSM plus datapath shifting; handshake outputs are registered with the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        carry    <= c_in;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    res   <= {nib_sum, res[WIDTH-1:4]};
                    carry <= nib_cout;
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    logic a_msb;
    logic b_msb;

    // Keep the operand sign bits from the handshake and form overflow on the final nibble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
            end
            if (state == RUN && cnt == LAST) begin
                ovf <= a_msb ^ b_msb ^ nib_sum[3] ^ nib_cout;
            end
        end
    end
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed testbench for nibble_serial_adder (WIDTH=16).
// If NIBBLE_SERIAL_ADDER_OVERFLOW_EN is defined, it also checks ovf.

module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        c_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        c_out;
    logic        busy;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int last_acc = 0;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    // 10 ns clock with a free-running cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        a        = av;
        b        = bv;
        c_in     = cv;
        in_valid = 1'b1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] es, input logic ec, input logic eo);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".sum"}, {16'd0, sum}, {16'd0, es});
        check({tag, ".cout"}, {31'd0, c_out}, {31'd0, ec});
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
        check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
`else
        if (eo === 1'bx) $display("[TB] unreachable");
`endif
    endtask

    // Call this at a negedge while the DUT is idle. It returns at a negedge, idle again if out_ready=1
    task automatic runOp(input string tag, input logic [15:0] av, input logic [15:0] bv, input logic cv,
                         input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        applyStimulus(av, bv, cv);
        check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        last_acc = cycle;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, lat, 32'd4);
        checkOutput(tag, es, ec, eo);
        if (out_ready) begin
            @(negedge clk);
            check({tag, ".pulse"}, {31'd0, out_valid}, 32'd0);
        end
    endtask

    initial begin
        int lat;
        int prev;
        logic [15:0] ra, rb;
        logic        rc;
        logic [16:0] rexp;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.in_ready", {31'd0, in_ready}, 32'd1);
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.sum", {16'd0, sum}, 32'd0);
        check("rst.cout", {31'd0, c_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed arithmetic vectors
        runOp("d1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        runOp("d2", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        prev = last_acc;
        runOp("d3", 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);
        check("d3.spacing", last_acc - prev, 32'd6);
        runOp("d4", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        runOp("d5", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        runOp("d6", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("d6.idle_sum", {16'd0, sum}, 32'd0);
        check("d6.idle_cout", {31'd0, c_out}, 32'd1);

        // Backpressure in DONE
        out_ready = 1'b0;
        runOp("bp", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
        applyStimulus(16'h0101, 16'h0202, 1'b0);
        repeat (5) begin
            @(negedge clk);
            check("bp.hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp.hold_sum", {16'd0, sum}, 32'h3333);
            check("bp.hold_cout", {31'd0, c_out}, 32'd0);
            check("bp.hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp.idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp.idle_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp.accepted_busy", {31'd0, busy}, 32'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp2.lat", lat, 32'd4);
        checkOutput("bp2", 16'h0303, 1'b0, 1'b0);
        @(negedge clk);

        // Asynchronous reset in the middle of RUN
        applyStimulus(16'hFFFF, 16'h0001, 1'b0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mrst.in_ready", {31'd0, in_ready}, 32'd1);
        check("mrst.out_valid", {31'd0, out_valid}, 32'd0);
        check("mrst.busy", {31'd0, busy}, 32'd0);
        check("mrst.sum", {16'd0, sum}, 32'd0);
        check("mrst.cout", {31'd0, c_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        runOp("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Back-to-back random operations with out_ready held high
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            rexp = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            prev = last_acc;
            runOp("rnd", ra, rb, rc, rexp[15:0], rexp[16],
                  ra[15] ^ rb[15] ^ rexp[15] ^ rexp[16]);
            if (i > 0) check("rnd.spacing", last_acc - prev, 32'd6);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
